operand_read: RTL
=================

# operand_read

Issue-side consumer of the two-read/one-write register file: drives its read addresses, merges same-cycle writeback data, and holds decoded operands in a valid/ready pipeline register for execute. It keeps a per-register pending scoreboard, set when an instruction that writes rd is accepted and cleared by writeback. While a source operand is pending, the stage stalls. It sits between decode and execute in the core pipeline.

## Interface
- WIDTH, 32, register data width
- NUM, 32, number of architectural registers; address width AW = $clog2(NUM)
- INFO_W, 32, opaque decode payload carried alongside the operands

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_rs1, in_rs2  in  AW  source register indices
- in_rs1_en, in_rs2_en  in  1  source is actually used (hazard check enable)
- in_rd  in  AW  destination index
- in_rd_en  in  1  instruction writes rd
- in_info  in  INFO_W  payload
- addr_r1, addr_r2  out  AW  register-file read addresses; combinational copies of in_rs1/in_rs2
- data_r1, data_r2  in  WIDTH  register-file read data; combinational, same cycle
- wb_valid  in  1  writeback this cycle; the same values drive the register-file write port
- wb_addr  in  AW  writeback index
- wb_data  in  WIDTH  writeback data
- flush  in  1  kill the stage contents and the scoreboard
- out_valid  out  1  operands valid to execute
- out_ready  in  1  execute accepts
- out_rs1_data, out_rs2_data  out  WIDTH  resolved operands
- out_rd, out_rd_en, out_info  out  AW/1/INFO_W  registered pass-through

## Operation
- Scoreboard `pending[NUM-1:0]`. Bit 0 is hard-wired to 0.
- Source hazard:
  - haz1 = in_rs1_en && pending[in_rs1] && !(wb_valid && wb_addr==in_rs1); haz2 is the same for rs2.
  - Without the bypass macro, the writeback exemption is removed.
- Handshake and accept:
  - in_ready = (!out_valid || out_ready) && !haz1 && !haz2 && !flush.
  - Accept = in_valid && in_ready.
- Operand selection at accept:
  - Index 0 gives 0.
  - Otherwise, if bypass is enabled and wb_valid && wb_addr==rs, the operand is wb_data.
  - Otherwise the operand is data_r.
- Scoreboard set: on accept with in_rd_en && in_rd!=0, set pending[in_rd].
- Scoreboard clear: wb_valid && wb_addr!=0 clears pending[wb_addr].
- Same register set and cleared in one cycle: set wins (a new producer supersedes the old one).
- Writeback to a non-pending register: harmless clear, no error.
- Output register:
  - Loads on accept.
  - On out_valid && out_ready without an accept, out_valid falls.
  - While out_valid && !out_ready, all out_* hold stable.
- flush:
  - Clears out_valid and every pending bit next edge; in_ready=0 that cycle.
  - Integration guarantees that no older writeback is outstanding when flush is raised.
  - A wb_valid in the flush cycle still updates the register file externally; the scoreboard ends all-zero.

## Timing
- Reset (async, reset_n=0): out_valid=0, pending all 0, out_rs1_data/out_rs2_data/out_rd/out_info=0, out_rd_en=0.
- in_ready is combinational from current-cycle inputs and state.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 per cycle when there are no hazards and out_ready=1.
- A dependent instruction directly behind its producer stalls until the producer's writeback cycle.
  - With bypass, it is accepted in the writeback cycle.
  - Without bypass, it is accepted in the cycle after writeback.
- Reset mid-stall drops everything; in_ready becomes valid from the first cycle after release.

## Configuration
- OPREAD_BYPASS_EN defined:
  - Writeback data is forwarded into the operand in the same cycle.
  - The pending check is satisfied by a matching wb_valid.
- OPREAD_BYPASS_EN undefined:
  - No forwarding mux.
  - Operands are always taken from data_r1/data_r2 (or 0 for index 0).
  - A pending source waits until pending has cleared, i.e. one extra stall cycle versus bypass.

## Test plan
- Reset then in_valid with rs1=3, rs2=4, regfile 3=0x11 and 4=0x22 -> next cycle out_valid=1, out_rs1_data=0x11, out_rs2_data=0x22.
- Accept rd=5 (rd_en=1), then rs1=5 issued; wb_valid with addr=5, data=0xAB arrives 3 cycles later:
  - With bypass: in_ready=0 for 3 cycles, accept in the wb cycle, out_rs1_data=0xAB.
  - Without bypass: accept one cycle later.
- rs1=0 with rd_en on x0 -> never stalls, operand=0, pending stays 0.
- out_ready=0 for 4 cycles with out_valid=1 -> outputs stable and in_ready=0; out_ready=1 -> next instruction accepted the same cycle.
- Accept rd=7 in the same cycle as wb_valid addr=7 -> pending[7]=1 afterwards; a following rs1=7 stalls.
- Pending 2, 9 set, then flush=1 -> next cycle out_valid=0, pending=0, and rs1=9 is accepted immediately.

Source files
------------

// File: rtl/operand_read_if.sv
// rtl/operand_read_if.sv - decode, register-file, writeback and execute signals of the operand-read stage
//
// Purpose: bundles every non-clock/reset signal of operand_read.
//   slave  modport : operand_read side (drives in_ready, addr_r*, out_*)
//   master modport : environment side (decode, register file, writeback, execute)
// Signals:
//   in_valid/in_ready, in_rs1/in_rs2(+_en), in_rd(+_en), in_info : decode offer
//   addr_r1/addr_r2 -> data_r1/data_r2                           : register-file read ports
//   wb_valid, wb_addr, wb_data                                   : writeback (also writes the register file)
//   flush                                                        : kill stage contents and scoreboard
//   out_valid/out_ready, out_rs1_data/out_rs2_data, out_rd(+_en), out_info : execute side
interface operand_read_if #(
    parameter int WIDTH  = 32,
    parameter int NUM    = 32,
    parameter int INFO_W = 32,
    parameter int AW     = $clog2(NUM)
);
    logic              in_valid;
    logic              in_ready;
    logic [AW-1:0]     in_rs1;
    logic [AW-1:0]     in_rs2;
    logic              in_rs1_en;
    logic              in_rs2_en;
    logic [AW-1:0]     in_rd;
    logic              in_rd_en;
    logic [INFO_W-1:0] in_info;
    logic [AW-1:0]     addr_r1;
    logic [AW-1:0]     addr_r2;
    logic [WIDTH-1:0]  data_r1;
    logic [WIDTH-1:0]  data_r2;
    logic              wb_valid;
    logic [AW-1:0]     wb_addr;
    logic [WIDTH-1:0]  wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_rs1_data;
    logic [WIDTH-1:0]  out_rs2_data;
    logic [AW-1:0]     out_rd;
    logic              out_rd_en;
    logic [INFO_W-1:0] out_info;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en, in_info,
        input  data_r1, data_r2, wb_valid, wb_addr, wb_data, flush, out_ready,
        output in_ready, addr_r1, addr_r2,
        output out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en, out_info
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_en, in_info,
        output data_r1, data_r2, wb_valid, wb_addr, wb_data, flush, out_ready,
        input  in_ready, addr_r1, addr_r2,
        input  out_valid, out_rs1_data, out_rs2_data, out_rd, out_rd_en, out_info
    );
endinterface

// File: rtl/operand_read.sv
// rtl/operand_read.sv - issue-side operand read with pending scoreboard and output pipeline register
//
// Purpose: drives register-file read addresses, resolves source operands (x0 -> 0,
// optional same-cycle writeback forwarding), stalls on pending sources, and holds
// the resolved instruction in a valid/ready register for execute.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : operand_read_if.slave (decode, register file, writeback, flush, execute)
// Configuration macro:
//   OPREAD_BYPASS_EN : when defined, a matching wb_valid satisfies the pending check and
//                      wb_data is forwarded into the operand in the same cycle.
module operand_read #(
    parameter int WIDTH  = 32,
    parameter int NUM    = 32,
    parameter int INFO_W = 32,
    parameter int AW     = $clog2(NUM)
) (
    input  logic          clock,
    input  logic          reset_n,
    operand_read_if.slave bus
);
    logic [NUM-1:0]    pending_q, pending_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0]  rs2_data_q, rs2_data_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic              rd_en_q, rd_en_d;
    logic [INFO_W-1:0] info_q, info_d;

    logic              haz1, haz2, ready, accept;
    logic              wb_hit1, wb_hit2;
    logic [WIDTH-1:0]  rs1_val, rs2_val;

    always_comb begin
        wb_hit1 = 1'b0;
        wb_hit2 = 1'b0;
`ifdef OPREAD_BYPASS_EN
        wb_hit1 = bus.wb_valid && (bus.wb_addr == bus.in_rs1);
        wb_hit2 = bus.wb_valid && (bus.wb_addr == bus.in_rs2);
`endif
        haz1   = bus.in_rs1_en && pending_q[bus.in_rs1] && !wb_hit1;
        haz2   = bus.in_rs2_en && pending_q[bus.in_rs2] && !wb_hit2;
        ready  = (!out_valid_q || bus.out_ready) && !haz1 && !haz2 && !bus.flush;
        accept = bus.in_valid && ready;

        // x0 always reads as zero regardless of what the register file returns.
        rs1_val = wb_hit1 ? bus.wb_data : bus.data_r1;
        rs2_val = wb_hit2 ? bus.wb_data : bus.data_r2;
        if (bus.in_rs1 == '0) rs1_val = '0;
        if (bus.in_rs2 == '0) rs2_val = '0;

        // Clear first, then set: a new producer accepted in the writeback cycle
        // of an older producer of the same register keeps the bit pending.
        pending_d = pending_q;
        if (bus.wb_valid && bus.wb_addr != '0) pending_d[bus.wb_addr] = 1'b0;
        if (accept && bus.in_rd_en && bus.in_rd != '0) pending_d[bus.in_rd] = 1'b1;
        if (bus.flush) pending_d = '0;
        pending_d[0] = 1'b0;

        out_valid_d = out_valid_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rd_d        = rd_q;
        rd_en_d     = rd_en_q;
        info_d      = info_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            rs1_data_d  = rs1_val;
            rs2_data_d  = rs2_val;
            rd_d        = bus.in_rd;
            rd_en_d     = bus.in_rd_en;
            info_d      = bus.in_info;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rd_q        <= '0;
            rd_en_q     <= 1'b0;
            info_q      <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rd_q        <= rd_d;
            rd_en_q     <= rd_en_d;
            info_q      <= info_d;
        end
    end

    assign bus.in_ready     = ready;
    assign bus.addr_r1      = bus.in_rs1;
    assign bus.addr_r2      = bus.in_rs2;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_rs1_data = rs1_data_q;
    assign bus.out_rs2_data = rs2_data_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_rd_en    = rd_en_q;
    assign bus.out_info     = info_q;
endmodule
